shift_sequencer: RTL and testbench

- Multi-cycle shift unit controller that shares one narrow shift stage between two requesters (req0: ALU shift path, req1: load/store byte-alignment path).
- Arbitrates round-robin, then iterates a shift of up to STEP bits per cycle until the full shift amount is consumed.
- Holds each result until the consumer accepts it.
- Sits beside the ALU in the execute stage; the single-cycle barrel shifter is replaced by this block when the area budget requires it.

---
 rtl/shift_sequencer_pkg.sv | 27 ++
 rtl/shift_sequencer_shift_step.sv | 31 +++
 rtl/shift_sequencer.sv | 159 +++++++++++++++
 tb/tb_shift_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shift_sequencer_pkg
// Purpose  : Shared shift type codes, FSM state encodings and default step
//            size for the multi-cycle shift sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package shift_sequencer_pkg;

  // Shift operation codes carried on reqN_type.
  localparam logic [1:0] C_TYPE_SRL  = 2'b00;
  localparam logic [1:0] C_TYPE_SLL  = 2'b01;
  localparam logic [1:0] C_TYPE_SRA  = 2'b10;
  localparam logic [1:0] C_TYPE_PASS = 2'b11;

  // Default bits shifted per iteration.
  localparam int C_DEFAULT_STEP = 8;

  // Sequencer states with explicit 2-bit encodings.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

endpackage
`default_nettype wire

// File: rtl/shift_sequencer_shift_step.sv
`default_nettype none
// ============================================================================
// Module   : shift_step
// Purpose  : Combinational 32-bit shift by 0..STEP bits (sll/srl/sra/pass).
// Revision : 1.0 - initial release
// ============================================================================
module shift_step
  import shift_sequencer_pkg::*;
#(
  parameter int STEP  = C_DEFAULT_STEP,
  parameter int AMT_W = $clog2(STEP + 1)
) (
  input  logic [31:0]      value,
  input  logic [AMT_W-1:0] amount,
  input  logic [1:0]       stype,
  output logic [31:0]      result
);

  // One bounded shift; sra replicates bit 31 so chained steps equal one shift.
  always_comb begin
    result = value;
    case (stype)
      C_TYPE_SLL: result = value << amount;
      C_TYPE_SRL: result = value >> amount;
      C_TYPE_SRA: result = $signed(value) >>> amount;
      default:    result = value;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : shift_sequencer
// Purpose  : Round-robin arbiter plus iterative shift controller sharing one
//            STEP-bit shift stage between two requesters. Results are held
//            until the consumer accepts them.
//            Optional macro SHIFT_SEQ_FLUSH_EN adds a flush input that drops
//            the in-flight operation and blocks accepts while asserted.
// Revision : 1.0 - initial release
// ============================================================================
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int STEP = C_DEFAULT_STEP,
  parameter int SHW  = 5
) (
  input  logic           clk,
  input  logic           rst,
`ifdef SHIFT_SEQ_FLUSH_EN
  input  logic           flush,
`endif
  input  logic           req0_valid,
  input  logic [31:0]    req0_a,
  input  logic [SHW-1:0] req0_shamt,
  input  logic [1:0]     req0_type,
  output logic           req0_ready,
  input  logic           req1_valid,
  input  logic [31:0]    req1_a,
  input  logic [SHW-1:0] req1_shamt,
  input  logic [1:0]     req1_type,
  output logic           req1_ready,
  output logic           res_valid,
  output logic [31:0]    res_data,
  output logic           res_id,
  input  logic           res_ready
);

  localparam int c_amt_w = $clog2(STEP + 1);

  state_t             r_state;
  logic               r_res_valid;
  logic [31:0]        r_data;
  logic               r_id;
  logic               r_last_grant;
  logic [SHW-1:0]     r_rem;
  logic [1:0]         r_type;

  logic               w_flush;
  logic               w_gnt0;
  logic               w_gnt1;
  logic               w_idle_ok;
  logic               w_accept;
  logic [31:0]        w_acc_a;
  logic [SHW-1:0]     w_acc_shamt;
  logic [1:0]         w_acc_type;
  logic [c_amt_w-1:0] w_step;
  logic [SHW-1:0]     w_rem_next;
  logic [31:0]        w_shifted;

`ifdef SHIFT_SEQ_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  // Round-robin grant: a lone requester wins, a tie goes to the one not served last.
  always_comb begin
    w_gnt0 = req0_valid && (!req1_valid ||  r_last_grant);
    w_gnt1 = req1_valid && (!req0_valid || !r_last_grant);
  end

  // Readys only in IDLE, never in reset or while flush blocks acceptance.
  assign w_idle_ok  = rst && (r_state == ST_IDLE) && !w_flush;
  assign req0_ready = w_idle_ok && w_gnt0;
  assign req1_ready = w_idle_ok && w_gnt1;
  assign w_accept   = req0_ready || req1_ready;

  assign w_acc_a     = w_gnt1 ? req1_a     : req0_a;
  assign w_acc_shamt = w_gnt1 ? req1_shamt : req0_shamt;
  assign w_acc_type  = w_gnt1 ? req1_type  : req0_type;

  // Per-cycle step is min(remaining, STEP); compared at 32 bits so any SHW works.
  always_comb begin
    w_step = c_amt_w'(STEP);
    if (32'(r_rem) < 32'(STEP)) begin
      w_step = c_amt_w'(r_rem);
    end
  end

  assign w_rem_next = r_rem - SHW'(w_step);

  shift_step #(
    .STEP  (STEP),
    .AMT_W (c_amt_w)
  ) u_shift_step (
    .value  (r_data),
    .amount (w_step),
    .stype  (r_type),
    .result (w_shifted)
  );

  // Sequencer FSM: accept in IDLE, iterate in SHIFT, hold result in DONE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_res_valid  <= 1'b0;
      r_data       <= '0;
      r_id         <= 1'b0;
      r_last_grant <= 1'b1;
      r_rem        <= '0;
      r_type       <= C_TYPE_SRL;
    end else if (w_flush && (r_state != ST_IDLE)) begin
      r_state     <= ST_IDLE;
      r_res_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_data       <= w_acc_a;
            r_rem        <= w_acc_shamt;
            r_type       <= w_acc_type;
            r_id         <= w_gnt1;
            r_last_grant <= w_gnt1;
            if ((w_acc_shamt == '0) || (w_acc_type == C_TYPE_PASS)) begin
              r_state     <= ST_DONE;
              r_res_valid <= 1'b1;
            end else begin
              r_state <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          r_data <= w_shifted;
          r_rem  <= w_rem_next;
          if (w_rem_next == '0) begin
            r_state     <= ST_DONE;
            r_res_valid <= 1'b1;
          end
        end
        ST_DONE: begin
          if (res_ready) begin
            r_state     <= ST_IDLE;
            r_res_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_res_valid <= 1'b0;
        end
      endcase
    end
  end

  assign res_valid = r_res_valid;
  assign res_data  = r_data;
  assign res_id    = r_id;

endmodule
`default_nettype wire

// File: tb/tb_shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_sequencer
// Purpose  : Self-checking bench for shift_sequencer with a result scoreboard
//            and a cycle-level grant/ready reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_sequencer;

  localparam int STEP = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        req0_valid = 1'b0;
  logic [31:0] req0_a = '0;
  logic [4:0]  req0_shamt = '0;
  logic [1:0]  req0_type = '0;
  logic        req0_ready;
  logic        req1_valid = 1'b0;
  logic [31:0] req1_a = '0;
  logic [4:0]  req1_shamt = '0;
  logic [1:0]  req1_type = '0;
  logic        req1_ready;
  logic        res_valid;
  logic [31:0] res_data;
  logic        res_id;
  logic        res_ready = 1'b1;

  shift_sequencer #(.STEP(STEP), .SHW(5)) dut (
    .clk        (clk),
    .rst        (rst),
`ifdef SHIFT_SEQ_FLUSH_EN
    .flush      (flush),
`endif
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_shamt (req0_shamt),
    .req0_type  (req0_type),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_shamt (req1_shamt),
    .req1_type  (req1_type),
    .req1_ready (req1_ready),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_id     (res_id),
    .res_ready  (res_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        id;
    logic [31:0] data;
    int          acc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;

  // Reference model state
  bit          m_busy = 1'b0;
  bit          m_last = 1'b1;
  bit          m_prev_valid = 1'b0;
  bit          m_hold = 1'b0;
  logic [31:0] m_hold_data;
  logic        m_hold_id;
  bit          stop_bp = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [4:0] sh,
                                            input logic [1:0] ty);
    case (ty)
      2'b01:   return a << sh;
      2'b00:   return a >> sh;
      2'b10:   return $signed(a) >>> sh;
      default: return a;
    endcase
  endfunction

  function automatic int ref_lat(input logic [4:0] sh, input logic [1:0] ty);
    if (sh == 5'd0 || ty == 2'b11) return 1;
    return 1 + (int'(sh) + STEP - 1) / STEP;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model and scoreboard, evaluated away from the active edge.
  always @(negedge clk) begin
    logic [1:0] exp_rdy;
    exp_t e;
    if (!rst) begin
      check("rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
      sb.delete();
      m_busy = 1'b0;
      m_last = 1'b1;
      m_prev_valid = 1'b0;
      m_hold = 1'b0;
    end else begin
      if (m_busy || flush) begin
        exp_rdy = 2'b00;
      end else begin
        exp_rdy[0] = req0_valid && (!req1_valid || m_last);
        exp_rdy[1] = req1_valid && (!req0_valid || !m_last);
      end
      check("ready", {30'd0, req1_ready, req0_ready}, {30'd0, exp_rdy});

      if (m_hold) begin
        check("hold_valid", {31'd0, res_valid}, 32'd1);
        check("hold_data", res_data, m_hold_data);
        check("hold_id", {31'd0, res_id}, {31'd0, m_hold_id});
      end

      if (res_valid && !m_prev_valid) begin
        if (sb.size() == 0) check("spurious_result", 32'd1, 32'd0);
        else check("latency", 32'(cyc - sb[0].acc), 32'(sb[0].lat));
      end

      if (flush && m_busy) begin
        if (sb.size() != 0) void'(sb.pop_front());
        m_busy = 1'b0;
        m_prev_valid = 1'b0;
        m_hold = 1'b0;
      end else begin
        if (res_valid && res_ready) begin
          if (sb.size() == 0) begin
            check("spurious_handshake", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            check("res_data", res_data, e.data);
            check("res_id", {31'd0, res_id}, {31'd0, e.id});
          end
          m_busy = 1'b0;
        end
        if (req0_valid && req0_ready) begin
          e.id = 1'b0; e.data = ref_shift(req0_a, req0_shamt, req0_type);
          e.acc = cyc; e.lat = ref_lat(req0_shamt, req0_type);
          sb.push_back(e);
          m_busy = 1'b1;
          m_last = 1'b0;
        end else if (req1_valid && req1_ready) begin
          e.id = 1'b1; e.data = ref_shift(req1_a, req1_shamt, req1_type);
          e.acc = cyc; e.lat = ref_lat(req1_shamt, req1_type);
          sb.push_back(e);
          m_busy = 1'b1;
          m_last = 1'b1;
        end
        m_hold = res_valid && !res_ready;
        m_hold_data = res_data;
        m_hold_id = res_id;
        m_prev_valid = res_valid;
      end
    end
  end

  // Present one request and hold it until the sequencer accepts it.
  task automatic issue(input int n, input logic [31:0] a, input logic [4:0] sh, input logic [1:0] ty);
    bit ok = 1'b0;
    @(posedge clk); #1;
    if (n == 0) begin
      req0_valid = 1'b1; req0_a = a; req0_shamt = sh; req0_type = ty;
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_shamt = sh; req1_type = ty;
    end
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if ((n == 0 && req0_ready) || (n == 1 && req1_ready)) begin
        ok = 1'b1;
        break;
      end
    end
    check("accept_timeout", {31'd0, ok}, 32'd1);
    @(posedge clk); #1;
    if (n == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk); #1;
      if (sb.size() == 0 && !m_busy) begin
        ok = 1'b1;
        break;
      end
    end
    check("drain_timeout", {31'd0, ok}, 32'd1);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_res_valid", {31'd0, res_valid}, 32'd0);
    check("rst_res_data", res_data, 32'd0);
    check("rst_res_id", {31'd0, res_id}, 32'd0);
    rst = 1'b1;

    // Long sll on req0, maximum iteration count
    issue(0, 32'h0000_0001, 5'd31, 2'b01);
    drain();

    // sra and srl from req1
    issue(1, 32'h8000_0000, 5'd4, 2'b10);
    drain();
    issue(1, 32'h8000_0000, 5'd4, 2'b00);
    drain();

    // Both requesters hold pass requests: grants must alternate
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_a = 32'h1111_1111; req0_shamt = 5'd0; req0_type = 2'b11;
    req1_valid = 1'b1; req1_a = 32'h2222_2222; req1_shamt = 5'd0; req1_type = 2'b11;
    repeat (12) @(posedge clk);
    #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    drain();

    // Consumer back-pressure with a pending request
    res_ready = 1'b0;
    issue(0, 32'h00FF_00FF, 5'd8, 2'b01);
    req1_valid = 1'b1; req1_a = 32'h1234_5678; req1_shamt = 5'd3; req1_type = 2'b11;
    repeat (12) @(posedge clk);
    #1;
    res_ready = 1'b1;
    begin
      bit ok = 1'b0;
      for (int k = 0; k < 50; k++) begin
        @(negedge clk);
        if (req1_ready) begin ok = 1'b1; break; end
      end
      check("bp_pending_accept", {31'd0, ok}, 32'd1);
      @(posedge clk); #1;
      req1_valid = 1'b0;
    end
    drain();

    // Reset in the middle of a SHIFT
    issue(0, 32'hFFFF_0000, 5'd20, 2'b00);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst_res_valid", {31'd0, res_valid}, 32'd0);
    check("midrst_res_data", res_data, 32'd0);
    rst = 1'b1;
    req0_valid = 1'b1; req0_a = 32'hCAFE_0001; req0_shamt = 5'd1; req0_type = 2'b01;
    req1_valid = 1'b1; req1_a = 32'hBEEF_0002; req1_shamt = 5'd1; req1_type = 2'b00;
    @(negedge clk);
    check("post_rst_prio", {30'd0, req1_ready, req0_ready}, 32'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    drain();

`ifdef SHIFT_SEQ_FLUSH_EN
    // Flush mid-SHIFT drops the result; flush in IDLE blocks accepts
    issue(0, 32'hA5A5_A5A5, 5'd31, 2'b01);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    req1_valid = 1'b1; req1_a = 32'h8765_4321; req1_shamt = 5'd13; req1_type = 2'b10;
    @(negedge clk);
    check("flush_idle_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    begin
      bit ok = 1'b0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (req1_ready) begin ok = 1'b1; break; end
      end
      check("post_flush_accept", {31'd0, ok}, 32'd1);
      @(posedge clk); #1;
      req1_valid = 1'b0;
    end
    drain();
`endif

    // Random traffic with random consumer back-pressure
    fork
      begin
        for (int k = 0; k < 16; k++) begin
          issue(int'($urandom_range(0, 1)), $urandom, 5'($urandom), 2'($urandom));
        end
        stop_bp = 1'b1;
      end
      begin
        while (!stop_bp) begin
          @(posedge clk); #1;
          res_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    @(posedge clk); #1;
    res_ready = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
